// File: rtl/audio_codec_i2s_if.sv
// Per-frame sample handshake between the effects datapath (master) and the
// serial-audio codec master (slave).
interface audio_codec_i2s_if #(
  parameter int unsigned SAMPLE_WIDTH = 16
);
  logic [SAMPLE_WIDTH-1:0] dac_left;
  logic [SAMPLE_WIDTH-1:0] dac_right;
  logic                    dac_valid;
  logic                    dac_ready;
  logic                    dac_underrun;
  logic [SAMPLE_WIDTH-1:0] adc_left;
  logic [SAMPLE_WIDTH-1:0] adc_right;
  logic                    adc_valid;

  modport master (
    output dac_left, dac_right, dac_valid,
    input  dac_ready, dac_underrun, adc_left, adc_right, adc_valid
  );

  modport slave (
    input  dac_left, dac_right, dac_valid,
    output dac_ready, dac_underrun, adc_left, adc_right, adc_valid
  );
endinterface

// File: rtl/audio_codec_i2s.sv
// Stereo I2S / left-justified codec master: generates BCLK/LRCK, shifts out a
// DAC sample pair and captures an ADC sample pair every frame.
module audio_codec_i2s #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned BCLK_DIV     = 4,
  parameter int unsigned SLOT_BITS    = 32,
  parameter int unsigned I2S_MODE     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  audio_codec_i2s_if.slave     bus,
  output logic                 AUD_BCLK,
  output logic                 AUD_DACLRCK,
  output logic                 AUD_ADCLRCK,
  output logic                 AUD_DACDAT,
  input  logic                 AUD_ADCDAT
);

  localparam int unsigned PW = $clog2(BCLK_DIV);
  localparam int unsigned BW = $clog2(SLOT_BITS);
  localparam int unsigned IW = $clog2(SAMPLE_WIDTH);

  localparam logic [PW-1:0] PH_LAST  = PW'(BCLK_DIV - 1);
  localparam logic [PW-1:0] PH_RISE  = PW'(BCLK_DIV / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(SLOT_BITS - 1);

  typedef logic [SAMPLE_WIDTH-1:0] sample_t;

  // The frame counter is kept as phase/bit/channel fields so no division by
  // non-power-of-two BCLK_DIV or SLOT_BITS is needed.
  logic [PW-1:0] phase_q, phase_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          chan_q, chan_d;
  logic          boundary_q, boundary_d;
  logic          bclk_q, bclk_d;
  logic          lrck_q, lrck_d;
  logic          dacdat_q, dacdat_d;
  sample_t       hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  sample_t       sh_l_q, sh_l_d, sh_r_q, sh_r_d;
  sample_t       adc_l_q, adc_l_d, adc_r_q, adc_r_d;

  logic [BW:0]   data_pos;
  logic          slot_active;
  logic [IW-1:0] sidx;
  sample_t       tx;

  always_comb begin
    phase_d = phase_q + 1'b1;
    bit_d   = bit_q;
    chan_d  = chan_q;
    if (phase_q == PH_LAST) begin
      phase_d = '0;
      if (bit_q == BIT_LAST) begin
        bit_d  = '0;
        chan_d = ~chan_q;
      end else begin
        bit_d = bit_q + 1'b1;
      end
    end
    boundary_d = chan_d && (bit_d == BIT_LAST) && (phase_d == PH_LAST);

    // Wraps to a large value before the I2S delay bit, so one compare covers both ends.
    data_pos    = {1'b0, bit_q} - (BW+1)'(I2S_MODE);
    slot_active = data_pos < (BW+1)'(SAMPLE_WIDTH);
    sidx        = IW'(SAMPLE_WIDTH - 1) - IW'(data_pos);
    tx          = chan_q ? hold_r_q : hold_l_q;

    bclk_d   = phase_q >= PH_RISE;
    lrck_d   = chan_q;
    dacdat_d = dacdat_q;
    if (phase_q == '0) begin
      dacdat_d = slot_active & tx[sidx];
    end

    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    if (boundary_q && bus.dac_valid) begin
      hold_l_d = bus.dac_left;
      hold_r_d = bus.dac_right;
    end

    sh_l_d = sh_l_q;
    sh_r_d = sh_r_q;
    if (phase_q == '0 && bit_q == '0) begin
      if (chan_q) sh_r_d = '0;
      else        sh_l_d = '0;
    end
    if (phase_q == PH_RISE && slot_active) begin
      if (chan_q) sh_r_d = {sh_r_q[SAMPLE_WIDTH-2:0], AUD_ADCDAT};
      else        sh_l_d = {sh_l_q[SAMPLE_WIDTH-2:0], AUD_ADCDAT};
    end

    // Loaded on entry to the boundary cycle so the data is valid alongside the pulse.
    adc_l_d = adc_l_q;
    adc_r_d = adc_r_q;
    if (boundary_d) begin
      adc_l_d = sh_l_d;
      adc_r_d = sh_r_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q    <= '0;
      bit_q      <= '0;
      chan_q     <= 1'b0;
      boundary_q <= 1'b0;
      bclk_q     <= 1'b0;
      lrck_q     <= 1'b0;
      dacdat_q   <= 1'b0;
      hold_l_q   <= '0;
      hold_r_q   <= '0;
      sh_l_q     <= '0;
      sh_r_q     <= '0;
      adc_l_q    <= '0;
      adc_r_q    <= '0;
    end else begin
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      chan_q     <= chan_d;
      boundary_q <= boundary_d;
      bclk_q     <= bclk_d;
      lrck_q     <= lrck_d;
      dacdat_q   <= dacdat_d;
      hold_l_q   <= hold_l_d;
      hold_r_q   <= hold_r_d;
      sh_l_q     <= sh_l_d;
      sh_r_q     <= sh_r_d;
      adc_l_q    <= adc_l_d;
      adc_r_q    <= adc_r_d;
    end
  end

  assign bus.dac_ready    = boundary_q;
  assign bus.adc_valid    = boundary_q;
  assign bus.dac_underrun = boundary_q & ~bus.dac_valid;
  assign bus.adc_left     = adc_l_q;
  assign bus.adc_right    = adc_r_q;

  assign AUD_BCLK    = bclk_q;
  assign AUD_DACLRCK = lrck_q;
  assign AUD_ADCLRCK = lrck_q;
  assign AUD_DACDAT  = dacdat_q;

endmodule

// File: doc/audio_codec_i2s.md
Name: audio_codec_i2s

Overview:
Parametrised stereo serial-audio master for the board codec. It generates BCLK and LRCK from the system clock, serialises a left/right DAC sample pair per frame, and deserialises a left/right ADC sample pair per frame. Sample width, bit-clock ratio, slot length and I2S versus left-justified framing are configurable. It connects to the effects datapath through a per-frame valid/ready handshake and supersedes the fixed 16-bit, single-channel-select driver.

Parameters:
SAMPLE_WIDTH, 16, bits per audio sample (8..32).
BCLK_DIV, 4, clk cycles per BCLK period; even, >= 4.
SLOT_BITS, 32, BCLK periods per channel slot; >= SAMPLE_WIDTH + I2S_MODE.
I2S_MODE, 1, 1 = I2S (MSB one BCLK after LRCK edge); 0 = left-justified (MSB on the LRCK edge).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
dac_left  in  SAMPLE_WIDTH  left sample for the next frame
dac_right  in  SAMPLE_WIDTH  right sample for the next frame
dac_valid  in  1  dac_left/dac_right are valid
dac_ready  out  1  one-cycle pulse; transfer occurs when dac_valid && dac_ready
dac_underrun  out  1  one-cycle pulse; no transfer occurred at frame boundary
adc_left  out  SAMPLE_WIDTH  last captured left sample
adc_right  out  SAMPLE_WIDTH  last captured right sample
adc_valid  out  1  one-cycle pulse; adc_left/adc_right updated
AUD_BCLK  out  1  codec bit clock
AUD_DACLRCK  out  1  DAC LR clock; 0 = left, 1 = right
AUD_ADCLRCK  out  1  ADC LR clock; identical to AUD_DACLRCK
AUD_DACDAT  out  1  serial DAC data
AUD_ADCDAT  in  1  serial ADC data

Behaviour:
- FRAME = 2*SLOT_BITS*BCLK_DIV. Free-running counter cnt runs 0..FRAME-1, then wraps to 0.
- Derived values:
  - phase = cnt mod BCLK_DIV
  - bit = (cnt/BCLK_DIV) mod SLOT_BITS
  - chan = (cnt >= FRAME/2)
- Clock pins:
  - AUD_BCLK = 1 when phase >= BCLK_DIV/2, else 0.
  - AUD_DACLRCK = AUD_ADCLRCK = chan.
- Data mapping: d = bit - I2S_MODE. If 0 <= d < SAMPLE_WIDTH, the slot carries sample bit [SAMPLE_WIDTH-1-d]. Otherwise AUD_DACDAT = 0 and ADC input is ignored.
- DAC timing: AUD_DACDAT updates when phase == 0 (BCLK falling edge) and is stable for the whole BCLK period.
- ADC timing: AUD_ADCDAT is sampled in the cycle with phase == BCLK_DIV/2 (BCLK rising) and shifted into a per-channel shift register. That register is cleared at its slot start.
- All pins are registered and share a uniform one-clk lag from cnt. No combinational path from inputs to pins.
- Frame boundary is the cycle with cnt == FRAME-1. In that cycle:
  - dac_ready = 1.
  - If dac_valid = 1, dac_left/dac_right are latched into the hold registers and used by the next frame.
  - If dac_valid = 0, dac_underrun = 1 and the hold registers keep their previous pair, which is replayed.
  - adc_valid = 1. adc_left/adc_right take the pair captured during the ending frame and hold until the next pulse.
- dac_ready, adc_valid and dac_underrun are never high outside the boundary cycle.
- Reset (asynchronous, any time including mid-frame):
  - cnt = 0; AUD_BCLK = 0; LRCK = 0; AUD_DACDAT = 0.
  - Hold, shift and adc registers = 0; all pulses = 0.
  - After release, the first frame starts at cnt = 0 with left channel and transmits zeros.
- Widths: no arithmetic on samples. Bits beyond SAMPLE_WIDTH in a slot transmit 0.

Test Plan:
1. Defaults, dac_valid held 1, left = 16'hA5C3, right = 16'h0F0F.
   -> Frame period 256 clk, BCLK period 4 clk, 32 BCLKs per slot.
   -> Second frame: DACDAT in left slot bits 1..16 = A5C3 MSB-first, bit 0 and bits 17..31 = 0.
   -> Right slot carries 0F0F at the same positions.
2. ADC model drives 16'h8001 (left) and 16'h7FFE (right), I2S-aligned.
   -> adc_valid pulses every 256 clk at cnt = 255.
   -> adc_left = 8001, adc_right = 7FFE after the first full frame.
3. I2S_MODE = 0, SAMPLE_WIDTH = 24, SLOT_BITS = 24, BCLK_DIV = 8.
   -> Frame = 384 clk.
   -> MSB coincides with the LRCK edge; full 24-bit loopback round-trips exactly.
4. Drop dac_valid for one boundary after sending 16'h1234/16'h4321.
   -> dac_underrun pulses once, next frame retransmits 1234/4321, no dac_ready transfer.
   -> Restore dac_valid with new data -> new data appears the frame after.
5. Assert reset at cnt = 100 for 3 clk.
   -> All outputs go to 0 immediately (asynchronous).
   -> After release, LRCK stays 0 for 128 clk, first boundary at 256 clk, first frame DACDAT all zero.
6. Check handshake pulses over 10 frames.
   -> dac_ready, adc_valid and dac_underrun are each exactly one clk wide and only at cnt = FRAME-1.
   -> BCLK duty is exactly 50%.
   -> DACDAT never changes except on cycles with phase == 0.
